bench_budget_multi: RTL and testbench

//  Parametrised multi-channel successor of the single-channel bounded-response synthesis bench.

---
 rtl/bench_budget_pkg.sv | 42 ++++
 rtl/bench_budget_multi_if.sv | 25 ++
 rtl/bench_budget_chan.sv | 52 +++++
 rtl/bench_budget_multi.sv | 104 ++++++++++
 tb/tb_bench_budget_multi.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bench_budget_pkg.sv
// Shared constants and helpers for the budgeted multi-channel response bench.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package bench_budget_pkg;

  // Widest channel vector the priority helper accepts.
  localparam int MAX_NCH = 32;

  // Default configuration of the bench.
  localparam int DEF_NCH    = 2;
  localparam int DEF_BUDGET = 2;
  localparam int DEF_WINDOW = 8;
  localparam int DEF_CW     = 3;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 31; b++) begin
      if ((1 << b) < v) r = b + 1;
    end
    return r;
  endfunction

  // True when a CW-bit counter can hold BUDGET and count to WINDOW-1.
  function automatic bit cw_fits(input int budget, input int window, input int cw);
    return (budget < (1 << cw)) && (window <= (1 << cw));
  endfunction

  localparam bit DEF_CW_OK = cw_fits(DEF_BUDGET, DEF_WINDOW, DEF_CW);

  // Index of the lowest set bit, or -1 when the vector is empty.
  function automatic int lowest_set(input logic [MAX_NCH-1:0] v);
    int idx;
    idx = -1;
    for (int b = MAX_NCH - 1; b >= 0; b--) begin
      if (v[b]) idx = b;
    end
    return idx;
  endfunction

endpackage

// File: rtl/bench_budget_multi_if.sv
// Request/grant/response bundle between the environment and the budget bench.
// Latency: n/a (wires only).
// Backpressure: none; the environment drives requests and grants freely.
interface bench_budget_multi_if #(
  parameter int NCH = 2
);
  logic [NCH-1:0] i;
  logic [NCH-1:0] controllable_i;
  logic [NCH-1:0] response;
  logic [NCH-1:0] err_chan;
  logic [NCH-1:0] _rt_get;
  logic           error;

  // Environment side: drives requests and grants, observes the bench.
  modport master (
    output i, controllable_i,
    input  response, err_chan, _rt_get, error
  );

  // Bench side.
  modport slave (
    input  i, controllable_i,
    output response, err_chan, _rt_get, error
  );
endinterface

// File: rtl/bench_budget_chan.sv
// One channel: credit counter, eligibility and miss/err_chan register.
// Latency: eligibility and miss are combinational; credit and err_chan update at the next edge.
// Backpressure: none; a request without a response in its cycle is recorded as a miss.
module bench_budget_chan
  import bench_budget_pkg::*;
#(
  parameter int BUDGET = DEF_BUDGET,
  parameter int CW     = DEF_CW,
  parameter int STICKY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_grant,
  input  logic i_elig_win,
  input  logic i_refill,
  output logic o_elig,
  output logic o_miss,
  output logic o_err_chan
);

  localparam logic [CW-1:0] LP_FULL = CW'(BUDGET);

  logic [CW-1:0] r_credit;
  logic          r_err_chan;

  // Pre-edge credit gates eligibility, so a channel at zero cannot be served.
  assign o_elig     = i_req & i_grant & (r_credit != '0);
  assign o_miss     = i_req & ~i_elig_win;
  assign o_err_chan = r_err_chan;

  // Credit: reload on the refill cycle, then subtract this cycle's service.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit <= LP_FULL;
    end else begin
      r_credit <= (i_refill ? LP_FULL : r_credit) - CW'(i_elig_win);
    end
  end

  // Per-channel miss record: latched or one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_chan <= 1'b0;
    end else if (STICKY != 0) begin
      r_err_chan <= r_err_chan | o_miss;
    end else begin
      r_err_chan <= o_miss;
    end
  end

endmodule

// File: rtl/bench_budget_multi.sv
// Multi-channel bounded-response bench: per-window credit budget, optional exclusive grant, error flag.
// Latency: response is combinational (same edge); error/err_chan are registered (one edge later).
// Backpressure: none; requests are never queued, an unserved request raises error.
module bench_budget_multi
  import bench_budget_pkg::*;
#(
  parameter int NCH       = DEF_NCH,
  parameter int BUDGET    = DEF_BUDGET,
  parameter int WINDOW    = DEF_WINDOW,
  parameter int CW        = DEF_CW,
  parameter int EXCLUSIVE = 0,
  parameter int STICKY    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  bench_budget_multi_if.slave bus
);

  // Reject configurations the counters cannot represent.
  if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
    $error("bench_budget_multi: NCH out of range");
  end
  if (BUDGET < 1 || !cw_fits(BUDGET, WINDOW, CW)) begin : g_bad_cw
    $error("bench_budget_multi: CW too narrow for BUDGET/WINDOW");
  end
  if (WINDOW == 1 || WINDOW < 0) begin : g_bad_window
    $error("bench_budget_multi: WINDOW must be 0 or >= 2");
  end

  localparam logic [CW-1:0] LP_WLAST = CW'((WINDOW == 0) ? 0 : WINDOW - 1);

  logic [CW-1:0]      r_wcnt;
  logic               r_error;
  logic               w_refill;
  logic [NCH-1:0]     w_elig;
  logic [NCH-1:0]     w_resp;
  logic [NCH-1:0]     w_miss;
  logic [NCH-1:0]     w_err_chan;
  logic [MAX_NCH-1:0] w_elig_ext;
  int                 w_win_idx;

  // The last cycle of a window is the refill cycle; WINDOW=0 never refills.
  assign w_refill = (WINDOW != 0) && (r_wcnt == LP_WLAST);

  // Window counter wraps on the refill cycle and is parked at 0 when refill is off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (WINDOW == 0 || w_refill) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 1'b1;
    end
  end

  // Arbitration: all eligible channels, or only the lowest-index one when exclusive.
  always_comb begin
    w_elig_ext            = '0;
    w_elig_ext[NCH-1:0]   = w_elig;
    w_win_idx             = lowest_set(w_elig_ext);
    w_resp                = w_elig;
    if (EXCLUSIVE != 0) begin
      for (int c = 0; c < NCH; c++) begin
        w_resp[c] = (w_win_idx == c);
      end
    end
  end

  // One credit/miss slice per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_chan
    bench_budget_chan #(
      .BUDGET (BUDGET),
      .CW     (CW),
      .STICKY (STICKY)
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (bus.i[c]),
      .i_grant    (bus.controllable_i[c]),
      .i_elig_win (w_resp[c]),
      .i_refill   (w_refill),
      .o_elig     (w_elig[c]),
      .o_miss     (w_miss[c]),
      .o_err_chan (w_err_chan[c])
    );
  end

  // Global error: OR of all channel misses, latched or pulsed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (STICKY != 0) begin
      r_error <= r_error | (|w_miss);
    end else begin
      r_error <= |w_miss;
    end
  end

  assign bus.response = w_resp;
  assign bus.err_chan = w_err_chan;
  assign bus.error    = r_error;
  assign bus._rt_get  = bus.i;

endmodule

// File: tb/tb_bench_budget_multi.sv
// Bench for bench_budget_multi: four configurations driven with identical stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_bench_budget_multi;

  localparam int NCH = 2;
  localparam int BUD = 2;
  localparam int NK  = 4;  // 0: default, 1: exclusive, 2: pulse, 3: no refill

  logic       clk = 1'b0;
  logic       r_rst_n;
  logic [1:0] r_i;
  logic [1:0] r_g;

  int n_checks;
  int n_errors;

  always #5 clk = ~clk;

  bench_budget_multi_if #(.NCH(NCH)) if_a ();
  bench_budget_multi_if #(.NCH(NCH)) if_b ();
  bench_budget_multi_if #(.NCH(NCH)) if_c ();
  bench_budget_multi_if #(.NCH(NCH)) if_d ();

  assign if_a.i = r_i;  assign if_a.controllable_i = r_g;
  assign if_b.i = r_i;  assign if_b.controllable_i = r_g;
  assign if_c.i = r_i;  assign if_c.controllable_i = r_g;
  assign if_d.i = r_i;  assign if_d.controllable_i = r_g;

  bench_budget_multi #(.NCH(NCH), .BUDGET(BUD), .WINDOW(8), .CW(3), .EXCLUSIVE(0), .STICKY(1))
    u_a (.clk(clk), .rst_n(r_rst_n), .bus(if_a));
  bench_budget_multi #(.NCH(NCH), .BUDGET(BUD), .WINDOW(8), .CW(3), .EXCLUSIVE(1), .STICKY(1))
    u_b (.clk(clk), .rst_n(r_rst_n), .bus(if_b));
  bench_budget_multi #(.NCH(NCH), .BUDGET(BUD), .WINDOW(8), .CW(3), .EXCLUSIVE(0), .STICKY(0))
    u_c (.clk(clk), .rst_n(r_rst_n), .bus(if_c));
  bench_budget_multi #(.NCH(NCH), .BUDGET(BUD), .WINDOW(0), .CW(3), .EXCLUSIVE(0), .STICKY(1))
    u_d (.clk(clk), .rst_n(r_rst_n), .bus(if_d));

  logic [1:0] d_resp [NK];
  logic [1:0] d_ec   [NK];
  logic [1:0] d_rt   [NK];
  logic       d_err  [NK];

  assign d_resp[0] = if_a.response;  assign d_ec[0] = if_a.err_chan;  assign d_err[0] = if_a.error;  assign d_rt[0] = if_a._rt_get;
  assign d_resp[1] = if_b.response;  assign d_ec[1] = if_b.err_chan;  assign d_err[1] = if_b.error;  assign d_rt[1] = if_b._rt_get;
  assign d_resp[2] = if_c.response;  assign d_ec[2] = if_c.err_chan;  assign d_err[2] = if_c.error;  assign d_rt[2] = if_c._rt_get;
  assign d_resp[3] = if_d.response;  assign d_ec[3] = if_d.err_chan;  assign d_err[3] = if_d.error;  assign d_rt[3] = if_d._rt_get;

  // ---------------- reference model (spec rules, plain arithmetic) ----------------
  int         m_credit [NK][NCH];
  int         m_cyc;
  logic       m_err    [NK];
  logic [1:0] m_ec     [NK];
  logic [1:0] s_resp   [NK];
  logic [1:0] e_resp   [NK];

  function automatic int cfg_exc(input int k);    return (k == 1) ? 1 : 0; endfunction
  function automatic int cfg_sticky(input int k); return (k == 2) ? 0 : 1; endfunction
  function automatic int cfg_win(input int k);    return (k == 3) ? 0 : 8; endfunction

  function automatic void m_reset();
    m_cyc = 0;
    for (int k = 0; k < NK; k++) begin
      m_err[k] = 1'b0;
      m_ec[k]  = '0;
      for (int c = 0; c < NCH; c++) m_credit[k][c] = BUD;
    end
  endfunction

  function automatic logic [1:0] model_resp(input int k, input logic [1:0] vi, input logic [1:0] vg);
    logic [1:0] r;
    bit taken;
    r = '0;
    taken = 0;
    for (int c = 0; c < NCH; c++) begin
      if (vi[c] && vg[c] && m_credit[k][c] > 0 && !(cfg_exc(k) == 1 && taken)) begin
        r[c] = 1'b1;
        taken = 1;
      end
    end
    return r;
  endfunction

  function automatic void model_edge(input logic [1:0] vi, input logic [1:0] vg);
    for (int k = 0; k < NK; k++) begin
      logic [1:0] resp, miss;
      int w;
      bit refill;
      resp   = model_resp(k, vi, vg);
      miss   = vi & ~resp;
      w      = cfg_win(k);
      refill = (w != 0) && ((m_cyc % w) == w - 1);
      for (int c = 0; c < NCH; c++)
        m_credit[k][c] = (refill ? BUD : m_credit[k][c]) - int'(resp[c]);
      if (cfg_sticky(k) == 1) begin
        m_ec[k]  = m_ec[k] | miss;
        m_err[k] = m_err[k] | (|miss);
      end else begin
        m_ec[k]  = miss;
        m_err[k] = |miss;
      end
    end
    m_cyc++;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  // One clock cycle: drive at negedge, capture pre-edge responses, advance model at posedge.
  task automatic cycle_io(input logic [1:0] vi, input logic [1:0] vg);
    @(negedge clk);
    r_i = vi;
    r_g = vg;
    #1;
    for (int k = 0; k < NK; k++) begin
      s_resp[k] = d_resp[k];
      e_resp[k] = model_resp(k, vi, vg);
    end
    @(posedge clk);
    model_edge(vi, vg);
    #1;
  endtask

  task automatic step_chk(input logic [1:0] vi, input logic [1:0] vg);
    cycle_io(vi, vg);
    for (int k = 0; k < NK; k++) begin
      chk2($sformatf("rand resp k%0d cyc%0d", k, m_cyc), s_resp[k], e_resp[k]);
      chk2($sformatf("rand rt_get k%0d", k), d_rt[k], vi);
      chk1($sformatf("rand error k%0d cyc%0d", k, m_cyc), d_err[k], m_err[k]);
      chk2($sformatf("rand err_chan k%0d cyc%0d", k, m_cyc), d_ec[k], m_ec[k]);
    end
  endtask

  // Synchronous-looking reset window; release lands between edges so the next edge is wcnt=0.
  task automatic do_reset();
    @(negedge clk);
    r_rst_n = 1'b0;
    r_i = 2'b11;
    r_g = 2'b00;
    m_reset();
    repeat (2) @(negedge clk);
    for (int k = 0; k < NK; k++) begin
      chk1($sformatf("reset error k%0d", k), d_err[k], 1'b0);
      chk2($sformatf("reset err_chan k%0d", k), d_ec[k], 2'b00);
      chk2($sformatf("reset resp nogrant k%0d", k), d_resp[k], 2'b00);
    end
    r_g = 2'b11;
    #1;
    chk2("reset resp grant k0", d_resp[0], 2'b11);
    chk2("reset resp grant k1", d_resp[1], 2'b01);
    @(negedge clk);
    r_i = 2'b00;
    r_g = 2'b00;
    @(posedge clk);
    #2;
    r_rst_n = 1'b1;
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset_chk();
    #2;
    r_rst_n = 1'b0;
    m_reset();
    #1;
    for (int k = 0; k < NK; k++) begin
      chk1($sformatf("async rst error k%0d", k), d_err[k], 1'b0);
      chk2($sformatf("async rst err_chan k%0d", k), d_ec[k], 2'b00);
      chk2($sformatf("async rst resp k%0d", k), d_resp[k], model_resp(k, r_i, r_g));
    end
    @(posedge clk);
    #2;
    r_rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic            rst;
    logic [1:0]      i;
    logic [1:0]      g;
    logic [2:0][1:0] resp;
    logic [2:0]      err;
    logic [2:0][1:0] ec;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [1:0] vi, input logic [1:0] vg,
                              input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rc,
                              input logic ea, input logic eb, input logic ec_,
                              input logic [1:0] ca, input logic [1:0] cb, input logic [1:0] cc);
    vec_t v;
    v.rst = rst;  v.i = vi;  v.g = vg;
    v.resp[0] = ra;  v.resp[1] = rb;  v.resp[2] = rc;
    v.err[0]  = ea;  v.err[1]  = eb;  v.err[2]  = ec_;
    v.ec[0]   = ca;  v.ec[1]   = cb;  v.ec[2]   = cc;
    return v;
  endfunction

  localparam int NV = 12;
  vec_t tv [NV];

  initial begin
    n_checks = 0;
    n_errors = 0;
    r_rst_n  = 1'b0;
    r_i      = '0;
    r_g      = '0;
    m_reset();

    //           rst  i      g      rA     rB     rC     eA eB eC  cA     cB     cC
    // budget exhaustion from wcnt=0
    tv[0]  = mk(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tv[1]  = mk(0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tv[2]  = mk(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 1, 2'b01, 2'b01, 2'b01);
    tv[3]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 2'b01, 2'b00);
    // exclusive arbitration: both request, lowest wins
    tv[4]  = mk(1, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 0, 1, 0, 2'b00, 2'b10, 2'b00);
    tv[5]  = mk(0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b10, 2'b00);
    // pulse mode: single miss at cycle 3
    tv[6]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tv[7]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tv[8]  = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 2'b00);
    tv[9]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 1, 2'b01, 2'b01, 2'b01);
    tv[10] = mk(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0, 2'b01, 2'b01, 2'b00);
    tv[11] = mk(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 1, 2'b11, 2'b11, 2'b10);

    for (int n = 0; n < NV; n++) begin
      if (tv[n].rst) do_reset();
      cycle_io(tv[n].i, tv[n].g);
      for (int k = 0; k < 3; k++) begin
        chk2($sformatf("tv%0d resp k%0d", n, k), s_resp[k], tv[n].resp[k]);
        chk1($sformatf("tv%0d error k%0d", n, k), d_err[k], tv[n].err[k]);
        chk2($sformatf("tv%0d err_chan k%0d", n, k), d_ec[k], tv[n].ec[k]);
      end
    end

    // Refill: ch0 served at cycles 0,1,8,9; without refill the third request misses.
    do_reset();
    for (int cyc = 0; cyc < 12; cyc++) begin
      logic [1:0] v;
      v = (cyc == 0 || cyc == 1 || cyc == 8 || cyc == 9) ? 2'b01 : 2'b00;
      cycle_io(v, v);
      if (v != 2'b00) chk2($sformatf("refill resp cyc%0d", cyc), s_resp[0], 2'b01);
      if (cyc == 8)   chk2("norefill resp cyc8", s_resp[3], 2'b00);
    end
    chk1("refill error", d_err[0], 1'b0);
    chk1("norefill error", d_err[3], 1'b1);
    chk2("norefill err_chan", d_ec[3], 2'b01);

    // Async reset mid-window with ch0 exhausted and error raised.
    do_reset();
    cycle_io(2'b01, 2'b01);
    cycle_io(2'b01, 2'b01);
    cycle_io(2'b01, 2'b01);
    cycle_io(2'b00, 2'b00);
    cycle_io(2'b00, 2'b00);
    chk1("pre async error", d_err[0], 1'b1);
    async_reset_chk();
    for (int n = 0; n < 2; n++) begin
      cycle_io(2'b01, 2'b01);
      chk2($sformatf("post async resp %0d", n), s_resp[0], 2'b01);
      chk1($sformatf("post async error %0d", n), d_err[0], 1'b0);
    end

    // Randomized traffic against the reference model, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 57) async_reset_chk();
      else step_chk(2'($urandom), 2'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
